// File: rtl/wb_button_debounce_pkg.sv
// ---------------------------------------------------------------------------
// wb_button_debounce_pkg
// Shared constants for the button debounce Wishbone slave: register offsets
// within the block's window, button count, event bit layout, a register
// select enum used by the address decoder, and a helper that packs
// press/release flags into the event/mask bit layout.
// No ports (package).
// ---------------------------------------------------------------------------
package wb_button_debounce_pkg;

  localparam int NUM_BUTTONS = 3;

  // Event/mask layout: presses in the low nibble, releases in the next one.
  localparam int PRESS_LSB   = 0;
  localparam int RELEASE_LSB = 4;

  // Byte offsets of the registers from the block's base address.
  localparam logic [31:0] STATUS_OFS = 32'd0;
  localparam logic [31:0] EVENT_OFS  = 32'd4;
  localparam logic [31:0] MASK_OFS   = 32'd8;
  localparam logic [31:0] COUNT_OFS  = 32'd12;

  // Bits of the event and mask registers that actually exist.
  localparam logic [31:0] EVENT_BITS = 32'h0000_0077;

  typedef enum logic [2:0] {
    REG_NONE,
    REG_STATUS,
    REG_EVENT,
    REG_MASK,
    REG_COUNT
  } regSel_t;

  function automatic logic [31:0] packEvents(input logic [NUM_BUTTONS-1:0] press,
                                             input logic [NUM_BUTTONS-1:0] rel);
    logic [31:0] word;
    word = '0;
    word[PRESS_LSB +: NUM_BUTTONS]   = press;
    word[RELEASE_LSB +: NUM_BUTTONS] = rel;
    return word;
  endfunction

endpackage

// File: rtl/wb_button_debounce_if.sv
// ---------------------------------------------------------------------------
// wb_button_debounce_if
// Classic single-cycle Wishbone bundle between a bus master and the button
// debounce slave. Signal names are given from the slave's point of view.
//   i_wb_cyc, i_wb_stb, i_wb_we : cycle, strobe, write enable
//   i_wb_addr, i_wb_data        : byte address, write data
//   o_wb_ack, o_wb_stall        : transfer complete, stall (always 0)
//   o_wb_data                   : read data
// ---------------------------------------------------------------------------
interface wb_button_debounce_if;

  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic        o_wb_stall;
  logic [31:0] o_wb_data;

  modport master (
    output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    input  o_wb_ack, o_wb_stall, o_wb_data
  );

  modport slave (
    input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
    output o_wb_ack, o_wb_stall, o_wb_data
  );

endinterface

// File: rtl/wb_button_debounce_bit.sv
// ---------------------------------------------------------------------------
// button_debounce_bit
// Two-flop synchroniser followed by a stability counter for one button pin.
// The clean level only follows the synchronised pin once it has disagreed
// with the clean level for DEBOUNCE_CYCLES consecutive clocks.
//   clk, reset : system clock, synchronous active-high reset
//   i_raw      : asynchronous button pin
//   o_clean    : debounced level
//   o_toggle   : high in the cycle whose clock edge flips o_clean
// ---------------------------------------------------------------------------
module button_debounce_bit #(
  parameter int               CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_clean,
  output logic o_toggle
);

  localparam logic [CNT_W-1:0] LAST_COUNT = DEBOUNCE_CYCLES - CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_clean;
  logic [CNT_W-1:0] r_cnt;
  logic             w_differ;

  assign w_differ = r_sync2 ^ r_clean;
  // Exposed combinationally so the parent can set event flags on the same
  // edge that the clean level changes.
  assign o_toggle = w_differ && (r_cnt == LAST_COUNT);
  assign o_clean  = r_clean;

  // Bring the pin into the clock domain, then count how long it has
  // disagreed with the accepted level. Any agreement restarts the count,
  // so a glitch shorter than the window can never reach the clean output.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_clean <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST_COUNT) begin
        r_clean <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/wb_button_debounce.sv
// ---------------------------------------------------------------------------
// wb_button_debounce
// Wishbone slave that debounces three button pins, feeds the clean levels
// to the LED peripheral, latches press/release events (write-1-to-clear)
// and raises a maskable level interrupt.
// Registers: STATUS (+0, RO levels), EVENT (+4, R/W1C), MASK (+8, RW) and,
// when BUTTON_PRESS_COUNT_EN is defined, COUNT (+12, saturating press
// counters, any write zeroes them).
//   clk, reset    : system clock, synchronous active-high reset
//   wb            : Wishbone slave bundle (wb_button_debounce_if.slave)
//   buttons_raw   : asynchronous button pins
//   buttons_clean : debounced levels
//   irq           : level interrupt, |(events & mask), registered
// ---------------------------------------------------------------------------
module wb_button_debounce
  import wb_button_debounce_pkg::*;
#(
  parameter logic [31:0]      BASE_ADDRESS    = 32'h0300_0100,
  parameter logic [31:0]      STATUS_ADDRESS  = BASE_ADDRESS + STATUS_OFS,
  parameter logic [31:0]      EVENT_ADDRESS   = BASE_ADDRESS + EVENT_OFS,
  parameter logic [31:0]      MASK_ADDRESS    = BASE_ADDRESS + MASK_OFS,
  parameter int               CNT_W           = 16,
  parameter logic [CNT_W-1:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic                   clk,
  input  logic                   reset,
  wb_button_debounce_if.slave    wb,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  output logic [NUM_BUTTONS-1:0] buttons_clean,
  output logic                   irq
);

  logic [NUM_BUTTONS-1:0] w_clean;
  logic [NUM_BUTTONS-1:0] w_toggle;
  logic [NUM_BUTTONS-1:0] w_press;
  logic [NUM_BUTTONS-1:0] w_rel;
  logic                   w_accept;
  logic                   w_wrEvent;
  logic                   w_wrMask;
  regSel_t                w_sel;
  logic [31:0]            w_rdMux;
  logic [31:0]            w_clearBits;
  logic [31:0]            w_countWord;

  logic [31:0]            r_events;
  logic [31:0]            r_mask;
  logic                   r_irq;
  logic                   r_ack;
  logic [31:0]            r_rdata;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_bit
    button_debounce_bit #(
      .CNT_W          (CNT_W),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (buttons_raw[i]),
      .o_clean (w_clean[i]),
      .o_toggle(w_toggle[i])
    );
  end

  assign w_press = w_toggle & ~w_clean;
  assign w_rel   = w_toggle & w_clean;

  assign buttons_clean = w_clean;
  assign irq           = r_irq;
  assign wb.o_wb_ack   = r_ack;
  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_data  = r_rdata;

  assign w_accept    = wb.i_wb_cyc && wb.i_wb_stb;
  assign w_wrEvent   = w_accept && wb.i_wb_we && (w_sel == REG_EVENT);
  assign w_wrMask    = w_accept && wb.i_wb_we && (w_sel == REG_MASK);
  assign w_clearBits = w_wrEvent ? (wb.i_wb_data & EVENT_BITS) : '0;

  // Full-address decode; anything not matched is unmapped and never acked.
  always_comb begin
    w_sel = REG_NONE;
    if (wb.i_wb_addr == STATUS_ADDRESS) begin
      w_sel = REG_STATUS;
    end else if (wb.i_wb_addr == EVENT_ADDRESS) begin
      w_sel = REG_EVENT;
    end else if (wb.i_wb_addr == MASK_ADDRESS) begin
      w_sel = REG_MASK;
`ifdef BUTTON_PRESS_COUNT_EN
    end else if (wb.i_wb_addr == BASE_ADDRESS + COUNT_OFS) begin
      w_sel = REG_COUNT;
`endif
    end
  end

  // Read mux sees the registers before this cycle's updates, so an EVENT
  // read returns the flags as they stood before any clear it accompanies.
  always_comb begin
    w_rdMux = '0;
    case (w_sel)
      REG_STATUS: w_rdMux = {{(32-NUM_BUTTONS){1'b0}}, w_clean};
      REG_EVENT:  w_rdMux = r_events;
      REG_MASK:   w_rdMux = r_mask;
      REG_COUNT:  w_rdMux = w_countWord;
      default:    w_rdMux = '0;
    endcase
  end

  // Events, mask, interrupt and bus response. New flags are OR'd in after
  // the clear so a coincident set always survives. irq looks at the
  // registered flags, so it trails every event/mask change by one cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_events <= '0;
      r_mask   <= '0;
      r_irq    <= 1'b0;
      r_ack    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_events <= (r_events & ~w_clearBits) | packEvents(w_press, w_rel);
      if (w_wrMask) begin
        r_mask <= wb.i_wb_data & EVENT_BITS;
      end
      r_irq <= |(r_events & r_mask);
      r_ack <= w_accept && (w_sel != REG_NONE);
      if (w_accept && !wb.i_wb_we) begin
        r_rdata <= w_rdMux;
      end
    end
  end

`ifdef BUTTON_PRESS_COUNT_EN
  logic [7:0] r_pressCnt [NUM_BUTTONS];
  logic       w_wrCount;

  assign w_wrCount = w_accept && wb.i_wb_we && (w_sel == REG_COUNT);

  // A clearing write that lands on a press leaves that press counted,
  // hence 1 rather than 0. Counters stick at 8'hFF.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) begin
        r_pressCnt[i] <= '0;
      end else if (w_wrCount) begin
        r_pressCnt[i] <= {7'b0, w_press[i]};
      end else if (w_press[i] && (r_pressCnt[i] != 8'hFF)) begin
        r_pressCnt[i] <= r_pressCnt[i] + 8'd1;
      end
    end
  end

  // Pack the counters one byte per button, button 0 in the low byte.
  always_comb begin
    w_countWord = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      w_countWord[8*i +: 8] = r_pressCnt[i];
    end
  end
`else
  assign w_countWord = '0;
`endif

endmodule

// File: tb/tb_wb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_wb_button_debounce
// Self-checking bench for wb_button_debounce with DEBOUNCE_CYCLES = 4.
// A reference model predicts clean levels from a sliding window of past pin
// samples and tracks events, mask, irq, ack and read data every cycle.
// Define BUTTON_PRESS_COUNT_EN to exercise the press counters.
// ---------------------------------------------------------------------------
module tb_wb_button_debounce;
  import wb_button_debounce_pkg::*;

  localparam logic [31:0] BASE = 32'h0300_0100;
  localparam int          DEB  = 4;
`ifdef BUTTON_PRESS_COUNT_EN
  localparam bit COUNT_EN = 1'b1;
`else
  localparam bit COUNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] buttons_raw;
  logic [2:0] buttons_clean;
  logic       irq;

  wb_button_debounce_if busIf();

  wb_button_debounce #(
    .BASE_ADDRESS   (BASE),
    .CNT_W          (16),
    .DEBOUNCE_CYCLES(16'(DEB))
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .wb           (busIf),
    .buttons_raw  (buttons_raw),
    .buttons_clean(buttons_clean),
    .irq          (irq)
  );

  always #5 clk = ~clk;

  int vecCount  = 0;
  int missCount = 0;
  bit checkEn   = 1'b0;

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCount++;
    if (obs !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // hist[0] is the pin value sampled at the latest edge. A button's clean
  // level flips when the samples from 2..DEB+1 edges ago all disagree with it.
  logic [2:0]  hist [0:DEB+1];
  logic [2:0]  mClean;
  logic [31:0] mEv, mMask, mRd;
  logic        mIrq, mAck;
  int          mCnt [3];

  function automatic bit modelMapped(input logic [31:0] a);
    return (a == BASE) || (a == BASE + 4) || (a == BASE + 8) || (COUNT_EN && a == BASE + 12);
  endfunction

  function automatic logic [31:0] modelRead(input logic [31:0] a);
    if (a == BASE)     return {29'b0, mClean};
    if (a == BASE + 4) return mEv;
    if (a == BASE + 8) return mMask;
    if (COUNT_EN && a == BASE + 12) return {8'h0, 8'(mCnt[2]), 8'(mCnt[1]), 8'(mCnt[0])};
    return 32'h0;
  endfunction

  always @(posedge clk) begin
    logic [2:0]  newClean, press, rel;
    logic [31:0] a, d, clr;
    bit          acc, wr, allDiffer;
    if (reset) begin
      for (int k = 0; k <= DEB + 1; k++) hist[k] = 3'b000;
      mClean = '0; mEv = '0; mMask = '0; mRd = '0; mIrq = 1'b0; mAck = 1'b0;
      for (int b = 0; b < 3; b++) mCnt[b] = 0;
    end else begin
      for (int k = DEB + 1; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = buttons_raw;
      newClean = mClean;
      for (int b = 0; b < 3; b++) begin
        allDiffer = 1'b1;
        for (int k = 2; k <= DEB + 1; k++) if (hist[k][b] == mClean[b]) allDiffer = 1'b0;
        if (allDiffer) newClean[b] = ~mClean[b];
      end
      press = newClean & ~mClean;
      rel   = mClean & ~newClean;
      acc = busIf.i_wb_cyc && busIf.i_wb_stb;
      wr  = busIf.i_wb_we;
      a   = busIf.i_wb_addr;
      d   = busIf.i_wb_data;
      if (acc && !wr) mRd = modelRead(a);
      mAck = acc && modelMapped(a);
      mIrq = |(mEv & mMask);
      clr  = (acc && wr && a == BASE + 4) ? d : 32'h0;
      mEv  = (mEv & ~clr) | {25'b0, rel, 1'b0, press};
      if (acc && wr && a == BASE + 8) mMask = d & 32'h77;
      if (COUNT_EN) begin
        for (int b = 0; b < 3; b++) begin
          if (acc && wr && a == BASE + 12) mCnt[b] = press[b] ? 1 : 0;
          else if (press[b] && mCnt[b] < 255) mCnt[b] = mCnt[b] + 1;
        end
      end
      mClean = newClean;
    end
  end

  // Continuous comparison against the model, half a cycle after each edge.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("clean", {29'b0, buttons_clean}, {29'b0, mClean});
      checkOutput("irq", {31'b0, irq}, {31'b0, mIrq});
      checkOutput("ack", {31'b0, busIf.o_wb_ack}, {31'b0, mAck});
      checkOutput("rdata", busIf.o_wb_data, mRd);
      checkOutput("stall", {31'b0, busIf.o_wb_stall}, 32'h0);
    end
  end

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic applyStimulus(input logic [2:0] raw);
    buttons_raw = raw;
  endtask

  task automatic busIdle();
    busIf.i_wb_cyc  = 1'b0;
    busIf.i_wb_stb  = 1'b0;
    busIf.i_wb_we   = 1'b0;
    busIf.i_wb_addr = '0;
    busIf.i_wb_data = '0;
  endtask

  task automatic wbAccess(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic ack);
    busIf.i_wb_cyc  = 1'b1;
    busIf.i_wb_stb  = 1'b1;
    busIf.i_wb_we   = we;
    busIf.i_wb_addr = addr;
    busIf.i_wb_data = wdata;
    @(posedge clk);
    @(negedge clk);
    rdata = busIf.o_wb_data;
    ack   = busIf.o_wb_ack;
    busIdle();
  endtask

  task automatic wbWrite(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        ack;
    wbAccess(1'b1, addr, wdata, rd, ack);
  endtask

  task automatic wbReadCheck(input string tag, input logic [31:0] addr,
                             input logic [31:0] expData, input logic expAck);
    logic [31:0] rd;
    logic        ack;
    wbAccess(1'b0, addr, 32'h0, rd, ack);
    checkOutput({tag, "_ack"}, {31'b0, ack}, {31'b0, expAck});
    if (expAck) checkOutput({tag, "_data"}, rd, expData);
  endtask

  task automatic waitClean(input int b, input logic val, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (buttons_clean[b] == val) ok = 1'b1;
    end
  endtask

  // ---------------- directed and random sequence ----------------
  initial begin
    bit          ok;
    logic [31:0] addrs [5];
    logic [31:0] rd;
    logic        ack;
    addrs[0] = BASE; addrs[1] = BASE + 4; addrs[2] = BASE + 8;
    addrs[3] = BASE + 12; addrs[4] = BASE + 16;

    reset = 1'b1;
    applyStimulus(3'b000);
    busIdle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkEn = 1'b1;
    checkOutput("rst_clean", {29'b0, buttons_clean}, 32'h0);
    checkOutput("rst_irq", {31'b0, irq}, 32'h0);
    checkOutput("rst_ack", {31'b0, busIf.o_wb_ack}, 32'h0);
    checkOutput("rst_rdata", busIf.o_wb_data, 32'h0);

    // Stable press on btn0: clean follows 2 + DEB edges later.
    reset = 1'b0;
    applyStimulus(3'b001);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("lat5", {29'b0, buttons_clean}, 32'h0);
    @(negedge clk);
    checkOutput("lat6", {29'b0, buttons_clean}, 32'h1);
    wbReadCheck("ev_first", BASE + 4, 32'h1, 1'b1);
    checkOutput("irq_masked", {31'b0, irq}, 32'h0);

    // Masked interrupt on press/release of btn0, then W1C.
    applyStimulus(3'b000);
    repeat (10) @(negedge clk);
    wbWrite(BASE + 4, 32'h77);
    wbWrite(BASE + 8, 32'h11);
    wbReadCheck("mask_rd", BASE + 8, 32'h11, 1'b1);
    applyStimulus(3'b001);
    waitClean(0, 1'b1, ok);
    checkOutput("press_seen", {31'b0, ok}, 32'h1);
    checkOutput("irq_same", {31'b0, irq}, 32'h0);
    @(negedge clk);
    checkOutput("irq_rise", {31'b0, irq}, 32'h1);
    applyStimulus(3'b000);
    repeat (10) @(negedge clk);
    wbReadCheck("ev_pr", BASE + 4, 32'h11, 1'b1);
    wbWrite(BASE + 4, 32'h11);
    checkOutput("irq_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    checkOutput("irq_fall", {31'b0, irq}, 32'h0);
    wbReadCheck("ev_clr", BASE + 4, 32'h0, 1'b1);

    // Glitches of DEB-1 cycles on btn1 never get through.
    for (int r = 0; r < 5; r++) begin
      applyStimulus(3'b010);
      repeat (3) @(negedge clk);
      applyStimulus(3'b000);
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("glitch_clean", {29'b0, buttons_clean}, 32'h0);
    wbReadCheck("glitch_ev", BASE + 4, 32'h0, 1'b1);

    // btn2 press lands on the same edge as a W1C of its flag: set wins.
    applyStimulus(3'b100);
    repeat (5) @(posedge clk);
    @(negedge clk);
    wbWrite(BASE + 4, 32'h4);
    checkOutput("coinc_clean", {29'b0, buttons_clean}, 32'h4);
    wbReadCheck("coinc_ev", BASE + 4, 32'h4, 1'b1);

    // Unmapped read: no ack for several cycles, then a normal STATUS read.
    wbAccess(1'b0, BASE + 16, 32'h0, rd, ack);
    checkOutput("unmap_ack", {31'b0, ack}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("unmap_noack", {31'b0, busIf.o_wb_ack}, 32'h0);
    end
    wbReadCheck("status", BASE, 32'h4, 1'b1);
    wbWrite(BASE, 32'hFFFF_FFFF);
    wbReadCheck("status_ro", BASE, 32'h4, 1'b1);

`ifdef BUTTON_PRESS_COUNT_EN
    wbWrite(BASE + 12, 32'h0);
    for (int p = 0; p < 300; p++) begin
      applyStimulus(3'b101);
      repeat (8) @(negedge clk);
      applyStimulus(3'b100);
      repeat (8) @(negedge clk);
    end
    wbReadCheck("count_sat", BASE + 12, 32'h0000_00FF, 1'b1);
    wbWrite(BASE + 12, 32'h1234_5678);
    wbReadCheck("count_clr", BASE + 12, 32'h0, 1'b1);
`else
    wbReadCheck("count_unmapped", BASE + 12, 32'h0, 1'b0);
`endif

    // Reset in the middle of a debounce window discards the partial count.
    applyStimulus(3'b010);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midrst_clean", {29'b0, buttons_clean}, 32'h0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("midrst_wait", {29'b0, buttons_clean}, 32'h0);
    wbReadCheck("midrst_mask", BASE + 8, 32'h0, 1'b1);

    // Randomised pins and bus traffic, checked cycle by cycle by the model.
    wbWrite(BASE + 8, $urandom);
    for (int it = 0; it < 300; it++) begin
      if ($urandom_range(0, 2) == 0) applyStimulus(3'($urandom));
      if ($urandom_range(0, 1) == 0) begin
        wbAccess(1'($urandom), addrs[$urandom_range(0, 4)], $urandom, rd, ack);
      end else begin
        repeat ($urandom_range(1, 8)) @(negedge clk);
      end
    end

    checkEn = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/wb_button_debounce.md
Name: wb_button_debounce

Overview:
Wishbone-slave input conditioner sitting directly upstream of the button/LED peripheral.
- Synchronises and debounces raw button pins.
- Drives the clean level bus into the LED peripheral's buttons input.
- Latches press/release events with write-1-to-clear semantics and raises a maskable interrupt.
- Software can poll levels or events over the same classic single-cycle Wishbone bus.

Parameters:
BASE_ADDRESS, 32'h03000100, base of this block's register window
STATUS_ADDRESS, BASE_ADDRESS, read-only debounced levels
EVENT_ADDRESS, BASE_ADDRESS+4, press/release event flags (R, W1C)
MASK_ADDRESS, BASE_ADDRESS+8, interrupt enable mask (RW)
CNT_W, 16, debounce counter width
DEBOUNCE_CYCLES, 16'd50000, stable cycles required before a level change is accepted (legal range 2..2^CNT_W-1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
i_wb_cyc  input  1  bus cycle active
i_wb_stb  input  1  strobe
i_wb_we  input  1  write enable
i_wb_addr  input  32  byte address
i_wb_data  input  32  write data
o_wb_ack  output  1  transfer complete
o_wb_stall  output  1  tied 0
o_wb_data  output  32  read data
buttons_raw  input  3  asynchronous button pins
buttons_clean  output  3  debounced levels, feeds LED peripheral buttons input
irq  output  1  level interrupt, active high

Behaviour:
- Reset (reset=1 at clk edge) clears all of the following to 0: buttons_clean, sync flops, counters, events, mask, irq, o_wb_ack, o_wb_data. Reset mid-debounce discards the partial count.
- Synchroniser: 2 flops per bit; sync = second stage.
- Debounce counter, per bit:
  - If sync == clean: counter <= 0.
  - Else if counter == DEBOUNCE_CYCLES-1: clean <= sync, counter <= 0.
  - Else counter <= counter+1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes clean.
  - Latency from a stable pin change to clean change = 2 + DEBOUNCE_CYCLES cycles.
- Events register (7 bits used):
  - Bits [2:0] set on a 0->1 transition of clean[i] (press).
  - Bits [6:4] set on a 1->0 transition of clean[i] (release).
  - Bit 3 and bits [31:7] read 0.
  - Flags are set in the same cycle clean changes.
  - A Wishbone write to EVENT_ADDRESS clears every bit written as 1.
  - If a set and a clear hit the same bit in the same cycle, set wins.
- Mask register: same bit layout as events; write stores i_wb_data[6:4] and [2:0]; other bits read 0.
- irq is registered: irq <= |(events & mask), i.e. one cycle after the event/mask update.
- Wishbone access:
  - Accepted when i_wb_cyc && i_wb_stb; o_wb_stall = 0.
  - Mapped address: o_wb_ack = 1 in the next cycle only, single-cycle pulse; back-to-back strobes give back-to-back acks.
  - Unmapped address: no ack.
  - Reads are registered in the accept cycle:
    - STATUS returns {29'b0, buttons_clean}.
    - EVENT returns the pre-clear value.
    - MASK returns the mask.
    - Unmapped reads load 0.
  - Writes to STATUS are ignored but acked.
  - o_wb_data holds its value when no read is accepted.

Optional Feature:
BUTTON_PRESS_COUNT_EN
- Defined:
  - Adds COUNT_ADDRESS = BASE_ADDRESS+12.
  - Three 8-bit saturating press counters, incremented on each press event, packed as [7:0]=btn0, [15:8]=btn1, [23:16]=btn2.
  - Counters stop at 8'hFF.
  - Any write to COUNT_ADDRESS zeroes all three.
  - If a write and an increment coincide, the counter ends at 1.
  - Reset clears the counters.
- Undefined: COUNT_ADDRESS is unmapped (no ack, no logic).

Decomposition:
- Shared package holds:
  - Register offset constants: STATUS 0, EVENT 4, MASK 8, COUNT 12.
  - NUM_BUTTONS = 3.
  - Event bit positions: PRESS_LSB = 0, RELEASE_LSB = 4.
- One sub-module, button_debounce_bit: the synchroniser plus counter for a single bit, parameterised by CNT_W and DEBOUNCE_CYCLES, instantiated 3 times.
- The top level contains the event, mask and count registers and the Wishbone decode.

Test Plan (bench uses DEBOUNCE_CYCLES=4):
- Hold buttons_raw=3'b001 stable -> buttons_clean=3'b001 exactly 6 cycles later; EVENT read = 32'h1; irq stays 0 (mask 0).
- Write MASK=32'h11, press then release btn0 -> irq rises 1 cycle after the press event; EVENT reads 32'h11; write EVENT=32'h11 -> EVENT reads 0, irq falls next cycle.
- Pulse buttons_raw[1] high for 3 cycles, repeated with 1-cycle gaps -> buttons_clean stays 3'b000, EVENT reads 0.
- Press btn2 so its event sets in the same cycle a W1C write of 32'h4 is accepted -> EVENT bit 2 remains 1.
- Read unmapped BASE+16 -> no o_wb_ack within 4 cycles; read STATUS afterwards -> ack next cycle with correct data.
- With BUTTON_PRESS_COUNT_EN: 300 btn0 presses -> COUNT reads 32'h000000FF; write COUNT -> reads 0. Without the macro: COUNT access gives no ack.
